// File: rtl/data_mem_pkg.sv
// Shared CPU package: command codes, FSM state encoding and helpers common to
// the control unit and the data memory.
package data_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_IDLE  = 8'hFF;

    localparam logic [7:0] CNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_IDLE,
        OP_ILLEGAL
    } op_t;

    // Any code outside the three legal ones, including X/Z, decodes as ILLEGAL.
    function automatic op_t decode_cmd(input logic [7:0] cmd);
        op_t op;
        case (cmd)
            CMD_READ:  op = OP_READ;
            CMD_WRITE: op = OP_WRITE;
            CMD_IDLE:  op = OP_IDLE;
            default:   op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port storage with synchronous write and registered synchronous read.
module mem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset on purpose; contents survive rst_n and stay
    // undefined until written, which lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem.sv
// CPU data memory: command FSM, saturating transaction counters, sticky
// illegal-command flag and tri-state control of the shared data bus.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd_memory,
    input  logic [ADDR_W-1:0] addr_memory,
    inout  wire  [DATA_W-1:0] data_memory,
    output logic [7:0]        rd_cnt,
    output logic [7:0]        wr_cnt,
    output logic              cmd_err
);

    op_t               op;
    state_t            state;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              drive_en;

    assign op = decode_cmd(cmd_memory);

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (op == OP_WRITE),
        .re    (op == OP_READ),
        .addr  (addr_memory),
        .wdata (data_memory),
        .rdata (rdata_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            cmd_err   <= 1'b0;
        end else begin
            case (op)
                OP_READ: begin
                    // A held READ at the same address is one transaction.
                    if (state != ST_RD || addr_memory != rd_addr_q) begin
                        rd_cnt <= sat_inc(rd_cnt);
                    end
                    rd_addr_q <= addr_memory;
                    state     <= ST_RD;
                end
                OP_WRITE: begin
                    if (state != ST_WR || addr_memory != wr_addr_q) begin
                        wr_cnt <= sat_inc(wr_cnt);
                    end
                    wr_addr_q <= addr_memory;
                    state     <= ST_WR;
                end
                OP_IDLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    cmd_err <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the enable is combinational so a change of cmd or addr drops the
    // driver in the same cycle; registering it would collide with the CPU on
    // a READ->WRITE turnaround.
    assign drive_en    = (state == ST_RD) && (op == OP_READ) && (addr_memory == rd_addr_q);
    assign data_memory = drive_en ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, reset/saturation
// sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [7:0]    cmd     = CMD_IDLE;
    logic [AW-1:0] addr    = '0;
    logic          tb_drv  = 1'b0;
    logic [DW-1:0] tb_data = '0;
    logic [7:0]    rd_cnt;
    logic [7:0]    wr_cnt;
    logic          cmd_err;

    // Pulled-up bus: a released bus reads back as all ones.
    tri1 [DW-1:0] bus;
    assign bus = tb_drv ? tb_data : {DW{1'bz}};

    always #5 clk = ~clk;

    data_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_memory  (cmd),
        .addr_memory (addr),
        .data_memory (bus),
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .cmd_err     (cmd_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one command for one cycle (from just after an edge), sample at the
    // falling edge, then advance past the next rising edge.
    task automatic apply(input logic [7:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] b, output logic [7:0] rc, output logic [7:0] wc,
                         output logic e);
        cmd     = c;
        addr    = a;
        tb_drv  = (c == CMD_WRITE);
        tb_data = d;
        @(negedge clk);
        b  = bus;
        rc = rd_cnt;
        wc = wr_cnt;
        e  = cmd_err;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_bus;
        logic [7:0] exp_rd;
        logic [7:0] exp_wr;
        logic       exp_err;
    } vec_t;

    vec_t tbl[16];

    // Behavioural model: memory image plus "what was the last sampled command".
    logic [DW-1:0] m_mem   [256];
    bit            m_known [256];
    int            m_rd, m_wr;
    bit            m_err;
    bit            m_last_was_rd, m_last_was_wr;
    logic [AW-1:0] m_last_rd_addr, m_last_wr_addr;

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_err = 0;
        m_last_was_rd = 0; m_last_was_wr = 0;
    endtask

    task automatic model_step(input logic [7:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] b, exp_b;
        logic [7:0]    rc, wc;
        logic          e;
        bit            exp_drive;
        exp_drive = m_last_was_rd && (c == CMD_READ) && (a == m_last_rd_addr);
        exp_b     = exp_drive ? m_mem[a] : ((c == CMD_WRITE) ? d : 8'hFF);
        apply(c, a, d, b, rc, wc, e);
        if (!exp_drive || m_known[a]) check("rand_bus", b, exp_b);
        check("rand_rd_cnt", rc, m_rd[7:0]);
        check("rand_wr_cnt", wc, m_wr[7:0]);
        check("rand_cmd_err", e, m_err);
        if (c == CMD_READ) begin
            if (!(m_last_was_rd && a == m_last_rd_addr)) m_rd = (m_rd < 255) ? m_rd + 1 : 255;
            m_last_rd_addr = a;
            m_last_was_rd = 1; m_last_was_wr = 0;
        end else if (c == CMD_WRITE) begin
            if (!(m_last_was_wr && a == m_last_wr_addr)) m_wr = (m_wr < 255) ? m_wr + 1 : 255;
            m_last_wr_addr = a;
            m_mem[a] = d; m_known[a] = 1;
            m_last_was_rd = 0; m_last_was_wr = 1;
        end else begin
            if (c != CMD_IDLE) m_err = 1;
            m_last_was_rd = 0; m_last_was_wr = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b;
        logic [7:0]    rc, wc;
        logic          e;
        logic [7:0]    c, a, d;

        // Write/read, held read, address change, illegal, turnaround.
        tbl[0]  = '{CMD_WRITE, 8'h11, 8'h3C, 8'h3C, 8'd0, 8'd0, 1'b0};
        tbl[1]  = '{CMD_WRITE, 8'h10, 8'hA5, 8'hA5, 8'd0, 8'd1, 1'b0};
        tbl[2]  = '{CMD_READ,  8'h10, 8'h00, 8'hFF, 8'd0, 8'd2, 1'b0};
        tbl[3]  = '{CMD_READ,  8'h10, 8'h00, 8'hA5, 8'd1, 8'd2, 1'b0};
        tbl[4]  = '{CMD_READ,  8'h10, 8'h00, 8'hA5, 8'd1, 8'd2, 1'b0};
        tbl[5]  = '{CMD_READ,  8'h10, 8'h00, 8'hA5, 8'd1, 8'd2, 1'b0};
        tbl[6]  = '{CMD_READ,  8'h11, 8'h00, 8'hFF, 8'd1, 8'd2, 1'b0};
        tbl[7]  = '{CMD_READ,  8'h11, 8'h00, 8'h3C, 8'd2, 8'd2, 1'b0};
        tbl[8]  = '{8'h07,     8'h11, 8'h00, 8'hFF, 8'd2, 8'd2, 1'b0};
        tbl[9]  = '{CMD_IDLE,  8'h11, 8'h00, 8'hFF, 8'd2, 8'd2, 1'b1};
        tbl[10] = '{CMD_READ,  8'h11, 8'h00, 8'hFF, 8'd2, 8'd2, 1'b1};
        tbl[11] = '{CMD_READ,  8'h11, 8'h00, 8'h3C, 8'd3, 8'd2, 1'b1};
        tbl[12] = '{CMD_WRITE, 8'h22, 8'h5A, 8'h5A, 8'd3, 8'd2, 1'b1};
        tbl[13] = '{CMD_IDLE,  8'h22, 8'h00, 8'hFF, 8'd3, 8'd3, 1'b1};
        tbl[14] = '{CMD_READ,  8'h22, 8'h00, 8'hFF, 8'd3, 8'd3, 1'b1};
        tbl[15] = '{CMD_READ,  8'h22, 8'h00, 8'h5A, 8'd4, 8'd3, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus", bus, 8'hFF);
        check("reset_rd_cnt", rd_cnt, 8'h00);
        check("reset_wr_cnt", wr_cnt, 8'h00);
        check("reset_cmd_err", cmd_err, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, b, rc, wc, e);
            check($sformatf("vec%0d_bus", i), b, tbl[i].exp_bus);
            check($sformatf("vec%0d_rd_cnt", i), rc, tbl[i].exp_rd);
            check($sformatf("vec%0d_wr_cnt", i), wc, tbl[i].exp_wr);
            check($sformatf("vec%0d_cmd_err", i), e, tbl[i].exp_err);
        end

        // Reset pulsed mid-read: bus released at once, contents survive.
        cmd = CMD_READ; addr = 8'h10; tb_drv = 1'b0;
        @(posedge clk);
        #3;
        check("midread_bus_before", bus, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("midread_bus_in_reset", bus, 8'hFF);
        check("midread_rd_cnt", rd_cnt, 8'h00);
        check("midread_wr_cnt", wr_cnt, 8'h00);
        check("midread_cmd_err", cmd_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_reset_read_bus", bus, 8'hA5);
        check("after_reset_rd_cnt", rd_cnt, 8'h01);
        @(posedge clk);
        #1;

        // 300 distinct-address writes saturate wr_cnt.
        for (int i = 0; i < 300; i++) begin
            d = 8'(i);
            apply(CMD_WRITE, 8'(i), d, b, rc, wc, e);
            if (i == 254) check("sat_wr_cnt_254", wc, 8'hFE);
            if (i == 255) check("sat_wr_cnt_255", wc, 8'hFF);
        end
        apply(CMD_IDLE, 8'h00, 8'h00, b, rc, wc, e);
        check("sat_wr_cnt_hold", wc, 8'hFF);
        check("sat_rd_cnt_unchanged", rc, 8'h01);

        // Randomized run against the model.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) model_step(CMD_WRITE, 8'h40 + 8'(i), 8'($urandom_range(0, 254)));
        a = 8'h40;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)      c = CMD_READ;
            else if (r < 80) c = CMD_WRITE;
            else if (r < 90) c = CMD_IDLE;
            else             c = 8'($urandom_range(2, 254));
            if ($urandom_range(0, 1) == 0) a = 8'h40 + 8'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 254));
            model_step(c, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
